// File: rtl/ctrl_pkg.sv
// Shared control-path definitions: opcodes, ALUOp encodings, stage bundle widths
// and the bubble value loaded into a stage register on stall, flush or reset.
package ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Control bits per stage; the destination register is appended by the user.
    // ID/EX:  reg_dst, branch, mem_read, mem_to_reg, alu_op[1:0], mem_write, alu_src, reg_write
    // EX/MEM: mem_read, mem_write, mem_to_reg, reg_write
    // MEM/WB: mem_to_reg, reg_write
    localparam int IDEX_CTRL_W  = 9;
    localparam int EXMEM_CTRL_W = 4;
    localparam int MEMWB_CTRL_W = 2;

    localparam logic BUBBLE_BIT = 1'b0;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline control register; rst or bubble loads the nop bundle.
module ctrl_stage_reg
    import ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || bubble) q <= {W{BUBBLE_BIT}};
        else               q <= d;
    end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// Carries decoded control down ID/EX, EX/MEM, MEM/WB; stalls on load-use,
// flushes on a taken branch resolved in EX, and counts both events.
module ctrl_pipe_hazard
    import ctrl_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_reg_dst,
    input  logic              id_branch,
    input  logic              id_mem_read,
    input  logic              id_mem_to_reg,
    input  logic [1:0]        id_alu_op,
    input  logic              id_mem_write,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_alu_zero,
    output logic              ex_reg_dst,
    output logic [1:0]        ex_alu_op,
    output logic              ex_alu_src,
    output logic              ex_branch,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [REG_AW-1:0] ex_dest,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              mem_mem_to_reg,
    output logic              mem_reg_write,
    output logic [REG_AW-1:0] mem_dest,
    output logic              wb_mem_to_reg,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_dest,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int IDEX_W  = IDEX_CTRL_W  + REG_AW;
    localparam int EXMEM_W = EXMEM_CTRL_W + REG_AW;
    localparam int MEMWB_W = MEMWB_CTRL_W + REG_AW;

    logic [REG_AW-1:0]  id_dest;
    logic               uses_rs, uses_rt, hz, bt;
    logic               ex_mem_to_reg, ex_reg_write;
    logic [IDEX_W-1:0]  idex_d, idex_q;
    logic [EXMEM_W-1:0] exmem_d, exmem_q;
    logic [MEMWB_W-1:0] memwb_d, memwb_q;

    assign id_dest = id_reg_dst ? id_rd : id_rt;
    assign uses_rs = id_valid;
    // rt is a source for R-type/beq (alu_src=0) and for sw (store data)
    assign uses_rt = id_valid & (~id_alu_src | id_mem_write);

    assign hz = ex_mem_read & (ex_dest != '0) &
                ((uses_rs & (ex_dest == id_rs)) | (uses_rt & (ex_dest == id_rt)));
    assign bt = ex_branch & ex_alu_zero;

    // A flush discards the ID instruction anyway, so it overrides the stall.
    assign if_id_flush = bt;
    assign pc_write    = bt | ~hz;
    assign if_id_write = bt | ~hz;

    assign idex_d = {id_reg_dst, id_branch, id_mem_read, id_mem_to_reg, id_alu_op,
                     id_mem_write, id_alu_src, id_reg_write, id_dest};
    assign {ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg, ex_alu_op,
            ex_mem_write, ex_alu_src, ex_reg_write, ex_dest} = idex_q;

    assign exmem_d = {ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_dest};
    assign {mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write, mem_dest} = exmem_q;

    assign memwb_d = {mem_mem_to_reg, mem_reg_write, mem_dest};
    assign {wb_mem_to_reg, wb_reg_write, wb_dest} = memwb_q;

    ctrl_stage_reg #(.W(IDEX_W)) u_idex (
        .clk(clk), .rst(rst), .bubble(bt | hz | ~id_valid), .d(idex_d), .q(idex_q)
    );

    ctrl_stage_reg #(.W(EXMEM_W)) u_exmem (
        .clk(clk), .rst(rst), .bubble(1'b0), .d(exmem_d), .q(exmem_q)
    );

    ctrl_stage_reg #(.W(MEMWB_W)) u_memwb (
        .clk(clk), .rst(rst), .bubble(1'b0), .d(memwb_d), .q(memwb_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (bt) begin
            if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end else if (hz) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
